an_frame_capture: RTL and testbench

Receive-side counterpart of the four-digit multiplexed display bus. It watches the anode-select vector and the 4-bit digit nibble produced by the display scan driver and rebuilds the 16-bit message, most significant digit first. It is used for on-chip loopback checking of the display path and as the capture front end when one board's display bus drives another board.

---
 rtl/an_bus_pkg.sv | 23 ++
 rtl/an_gap_timer.sv | 22 ++
 rtl/an_frame_capture.sv | 76 +++++++
 tb/tb_an_frame_capture.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/an_bus_pkg.sv
// an_bus_pkg: anode codes, capture FSM states and anode decode helpers shared by the display bus blocks.
package an_bus_pkg;
    localparam logic [3:0] AN_D3    = 4'b0111;
    localparam logic [3:0] AN_D2    = 4'b1011;
    localparam logic [3:0] AN_D1    = 4'b1101;
    localparam logic [3:0] AN_D0    = 4'b1110;
    localparam logic [3:0] AN_BLANK = 4'b1111;

    typedef enum logic [1:0] {WAIT_D3, WAIT_D2, WAIT_D1, WAIT_D0} state_t;

    function automatic logic an_is_digit(input logic [3:0] an);
        return an == AN_D3 || an == AN_D2 || an == AN_D1 || an == AN_D0;
    endfunction

    function automatic logic [1:0] an_pos(input logic [3:0] an);
        return an == AN_D3 ? 2'd3 : an == AN_D2 ? 2'd2 : an == AN_D1 ? 2'd1 : 2'd0;
    endfunction

    // Active-low one-hot code selecting digit n.
    function automatic logic [3:0] an_code(input logic [1:0] n);
        return ~(4'b0001 << n);
    endfunction
endpackage

// File: rtl/an_gap_timer.sv
// an_gap_timer: counts consecutive enabled cycles; expired fires on the GAP_MAX-th one and restarts the count.
module an_gap_timer #(
    parameter int GAP_MAX = 15,
    parameter int GAP_W   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    logic [GAP_W-1:0] cnt;

    assign expired = en && !clr && cnt == GAP_W'(GAP_MAX - 1);

    always_ff @(posedge clk) begin
        if (!reset || clr || expired)
            cnt <= '0;
        else if (en && cnt != GAP_W'(GAP_MAX - 1))
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/an_frame_capture.sv
// an_frame_capture: rebuilds {D3,D2,D1,D0} frames from a multiplexed display bus.
// Captures each digit on an anode change, flags ordering, illegal-anode and gap violations.
module an_frame_capture
    import an_bus_pkg::*;
#(
    parameter int GAP_MAX = 15,
    parameter int GAP_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [3:0]  digit,
    output logic [15:0] message,
    output logic        frame_valid,
    output logic        frame_err,
    output logic        busy
);
    state_t      state;
    logic [3:0]  prev_an;
    logic [15:0] shadow;
    logic        cap;
    logic        bad;
    logic        expired;

    assign cap  = an_is_digit(an) && an != prev_an;
    assign bad  = !an_is_digit(an) && an != AN_BLANK;
    assign busy = state != WAIT_D3;

    an_gap_timer #(.GAP_MAX(GAP_MAX), .GAP_W(GAP_W)) u_gap (
        .clk     (clk),
        .reset   (reset),
        .clr     (!busy || an != AN_BLANK),
        .en      (busy && an == AN_BLANK),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= WAIT_D3;
            prev_an     <= AN_BLANK;
            shadow      <= '0;
            message     <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            prev_an     <= an;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (state == WAIT_D3) begin
                if (cap && an == AN_D3) begin
                    shadow <= {digit, 12'h000};
                    state  <= WAIT_D2;
                end
            end else if (bad || expired) begin
                frame_err <= 1'b1;
                shadow    <= '0;
                state     <= WAIT_D3;
            end else if (cap && an == an_code(~state)) begin
                if (state == WAIT_D0) begin
                    message     <= {shadow[15:4], digit};
                    frame_valid <= 1'b1;
                    shadow      <= '0;
                    state       <= WAIT_D3;
                end else begin
                    shadow[{an_pos(an), 2'b00} +: 4] <= digit;
                    state <= state_t'(state + 2'd1);
                end
            end else if (cap) begin
                // An early D3 restarts assembly rather than being lost.
                frame_err <= 1'b1;
                shadow    <= an == AN_D3 ? {digit, 12'h000} : 16'h0000;
                state     <= an == AN_D3 ? WAIT_D2 : WAIT_D3;
            end
        end
    end
endmodule

// File: tb/tb_an_frame_capture.sv
// tb_an_frame_capture: directed scans checked against a queue-based frame model every cycle plus literal expectations.
module tb_an_frame_capture;
    localparam int GAP_MAX = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  an = 4'hF;
    logic [3:0]  digit = 4'h0;
    logic [15:0] message;
    logic        frame_valid;
    logic        frame_err;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int n_fv = 0;
    int n_fe = 0;
    bit armed = 1'b0;

    an_frame_capture #(.GAP_MAX(GAP_MAX), .GAP_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .an          (an),
        .digit       (digit),
        .message     (message),
        .frame_valid (frame_valid),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Model: nibbles captured so far in the current frame, in arrival order.
    logic [3:0]  got[$];
    logic [3:0]  m_prev = 4'hF;
    logic [15:0] m_msg = 16'h0;
    logic        m_fv = 1'b0;
    logic        m_fe = 1'b0;
    int          m_gap = 0;

    always @(posedge clk) begin
        int  dig;
        bit  cap;
        bit  bad;
        dig = -1;
        for (int i = 0; i < 4; i++)
            if (an === (4'hF ^ (4'h1 << i))) dig = i;
        cap = dig >= 0 && an !== m_prev;
        bad = dig < 0 && an !== 4'hF;
        m_fv = 1'b0;
        m_fe = 1'b0;
        if (!reset) begin
            got.delete();
            m_prev = 4'hF;
            m_msg = 16'h0;
            m_gap = 0;
        end else begin
            m_prev = an;
            m_gap = (got.size() > 0 && an === 4'hF) ? m_gap + 1 : 0;
            if (got.size() == 0) begin
                if (cap && dig == 3) got.push_back(digit);
            end else if (bad || m_gap == GAP_MAX) begin
                m_fe = 1'b1;
                m_gap = 0;
                got.delete();
            end else if (cap && dig == 3 - got.size()) begin
                got.push_back(digit);
                if (got.size() == 4) begin
                    m_msg = {got[0], got[1], got[2], got[3]};
                    m_fv = 1'b1;
                    got.delete();
                end
            end else if (cap) begin
                m_fe = 1'b1;
                got.delete();
                if (dig == 3) got.push_back(digit);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            check("message", 32'(message), 32'(m_msg));
            check("frame_valid", 32'(frame_valid), 32'(m_fv));
            check("frame_err", 32'(frame_err), 32'(m_fe));
            check("busy", 32'(busy), 32'(got.size() != 0));
            check("valid_err_excl", 32'(frame_valid & frame_err), 32'd0);
            if (frame_valid === 1'b1) n_fv++;
            if (frame_err === 1'b1) n_fe++;
        end
    end

    function automatic logic [3:0] code(input int i);
        return 4'hF ^ (4'h1 << i);
    endfunction

    task automatic drive(input logic [3:0] a, input logic [3:0] d, input int n);
        an = a;
        digit = d;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic scan(input logic [15:0] msg, input int blanks);
        for (int i = 3; i >= 0; i--) begin
            drive(code(i), msg[4*i +: 4], 1);
            drive(4'hF, 4'h0, blanks);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(4'hF, 4'h0, 2);
        reset = 1'b1;
        n_fv = 0;
        n_fe = 0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        armed = 1'b1;
        check("rst_message", 32'(message), 32'h0);
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        do_reset();
        scan(16'hA5C3, 3);
        scan(16'hA5C3, 3);
        check("t1_message", 32'(message), 32'hA5C3);
        check("t1_valid_count", 32'(n_fv), 32'd2);
        check("t1_err_count", 32'(n_fe), 32'd0);

        reset = 1'b0;
        drive(code(3), 4'h1, 1);
        drive(4'hF, 4'h0, 3);
        drive(code(2), 4'h2, 1);
        drive(4'hF, 4'h0, 3);
        reset = 1'b1;
        n_fv = 0;
        n_fe = 0;
        drive(code(1), 4'h3, 1);
        drive(4'hF, 4'h0, 3);
        drive(code(0), 4'h4, 1);
        drive(4'hF, 4'h0, 3);
        check("t2_busy_after_hunt", 32'(busy), 32'd0);
        check("t2_message_before", 32'(message), 32'h0);
        scan(16'h5678, 3);
        check("t2_message", 32'(message), 32'h5678);
        check("t2_valid_count", 32'(n_fv), 32'd1);
        check("t2_err_count", 32'(n_fe), 32'd0);

        do_reset();
        drive(code(3), 4'h9, 1);
        drive(code(2), 4'h8, 1);
        drive(code(0), 4'h1, 1);
        check("t3_err_pulse", 32'(frame_err), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        drive(4'hF, 4'h0, 2);
        check("t3_message", 32'(message), 32'h0);

        do_reset();
        drive(code(3), 4'h1, 1);
        drive(code(2), 4'h2, 1);
        drive(code(3), 4'hB, 1);
        check("t4_restart_busy", 32'(busy), 32'd1);
        drive(code(2), 4'hE, 1);
        drive(code(1), 4'hE, 1);
        drive(code(0), 4'hF, 1);
        drive(4'hF, 4'h0, 2);
        check("t4_message", 32'(message), 32'hBEEF);
        check("t4_err_count", 32'(n_fe), 32'd1);
        check("t4_valid_count", 32'(n_fv), 32'd1);

        do_reset();
        drive(code(3), 4'h7, 5);
        drive(code(2), 4'h1, 1);
        drive(code(1), 4'h2, 1);
        drive(code(0), 4'h3, 1);
        check("t5_message", 32'(message), 32'h7123);
        check("t5_valid", 32'(frame_valid), 32'd1);
        drive(4'hF, 4'h0, 2);
        check("t5_err_count", 32'(n_fe), 32'd0);

        do_reset();
        drive(code(3), 4'h4, 1);
        drive(code(2), 4'h5, 1);
        drive(4'hF, 4'h0, 14);
        check("t6_busy_at_14", 32'(busy), 32'd1);
        check("t6_no_err_at_14", 32'(n_fe), 32'd0);
        drive(4'hF, 4'h0, 1);
        check("t6_err_at_15", 32'(frame_err), 32'd1);
        check("t6_busy_after", 32'(busy), 32'd0);
        drive(4'hF, 4'h0, 20);
        check("t6_single_err", 32'(n_fe), 32'd1);

        do_reset();
        drive(code(3), 4'h4, 1);
        drive(code(2), 4'h5, 1);
        drive(4'hF, 4'h0, 14);
        drive(code(1), 4'h6, 1);
        drive(code(0), 4'h7, 1);
        check("t6b_message", 32'(message), 32'h4567);
        drive(4'hF, 4'h0, 2);
        check("t6b_err_count", 32'(n_fe), 32'd0);

        do_reset();
        drive(4'b0011, 4'h0, 2);
        check("t7_idle_illegal", 32'(n_fe), 32'd0);
        drive(code(3), 4'hC, 1);
        drive(4'b0011, 4'h0, 1);
        check("t7_err", 32'(frame_err), 32'd1);
        check("t7_busy", 32'(busy), 32'd0);
        drive(4'hF, 4'h0, 3);
        check("t7_message", 32'(message), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
